score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter LIVES, default 3: lives granted at game start, range 1..7.
REQ-002 Parameter HITS_PER_LEVEL, default 8: accepted hits needed to advance one level, range 1..255.
REQ-003 Parameter MAX_LEVEL, default 7: level ceiling, range 0..7.
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port enable, input, 1: high = play advances; low in PLAY = pause.
REQ-007 Port start, input, 1: single-cycle request to begin a new game.
REQ-008 Port hit, input, 1: single-cycle pulse from the hit detector.
REQ-009 Port miss, input, 1: single-cycle pulse from the hit detector.
REQ-010 Port score_bcd, output, 12: three BCD digits, hundreds in [11:8], tens in [7:4], units in [3:0].
REQ-011 Port lives_left, output, 3: remaining lives.
REQ-012 Port level, output, 3: current difficulty; feeds the pulse generator's difficulty input.
REQ-013 Port streak, output, 8: consecutive hits since the last miss.
REQ-014 Port playing, output, 1: high while state is PLAY.
REQ-015 Port game_over, output, 1: high while state is OVER.

Function
REQ-016 The FSM SHALL have three states: IDLE, PLAY and OVER.
REQ-017 State transitions SHALL be as follows:
- IDLE --start--> PLAY.
- PLAY --(lives_left becomes 0)--> OVER.
- OVER --start--> PLAY.
- start in PLAY is ignored.
REQ-018 Entering PLAY SHALL, in the same edge:
- clear score_bcd, streak, level and the internal hit counter to 0;
- load lives_left = LIVES.
REQ-019 All outputs SHALL be registered; a hit or miss accepted at edge N SHALL be visible after edge N.
REQ-020 Pulse acceptance: hit and miss SHALL be accepted only when state = PLAY and enable = 1; otherwise they are ignored, and all counters hold.
REQ-021 An accepted hit SHALL:
- increment score_bcd by 1 with decimal carry between digits (009->010, 099->100);
- saturate score_bcd at 999;
- increment streak, saturating at 255;
- increment the internal hit counter.
REQ-022 When the internal hit counter reaches HITS_PER_LEVEL, the counter SHALL wrap to 0 and level SHALL increment, saturating at MAX_LEVEL; the counter keeps wrapping after saturation.
REQ-023 An accepted miss SHALL clear streak to 0 and decrement lives_left by 1.
REQ-024 A miss that takes lives_left from 1 to 0 SHALL move the FSM to OVER on the same edge.
REQ-025 When hit and miss are accepted in the same cycle, only the hit SHALL take effect and the miss SHALL be discarded.
REQ-026 In OVER, score_bcd, level and streak SHALL hold their final values and lives_left SHALL stay 0 until the next start.
REQ-027 playing and game_over SHALL decode directly from state registers; they are never both high.
REQ-028 No BCD digit SHALL ever hold a value above 9.

Reset
REQ-029 While rst = 0, outputs SHALL asynchronously become:
- state = IDLE;
- score_bcd = 12'h000, lives_left = 0, level = 0, streak = 0;
- internal hit counter = 0;
- playing = 0, game_over = 0.
REQ-030 Reset asserted mid-game SHALL abandon the game with no partial update.
REQ-031 After rst deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-032 Reset, then start -> next cycle: playing = 1, lives_left = 3, score_bcd = 000, level = 0.
REQ-033 In PLAY, 10 hits -> score_bcd = 12'h010, streak = 10, level = 1 (defaults).
REQ-034 In PLAY, hit and miss in the same cycle -> score +1, lives_left unchanged, streak +1.
REQ-035 In PLAY, three misses -> lives_left 3->2->1->0, game_over = 1; a subsequent hit leaves score unchanged; start -> playing = 1, score = 000.
REQ-036 In PLAY, 1000 hits -> score_bcd = 12'h999, streak = 255, level = 7; hits with enable = 0 change nothing.
REQ-037 Assert rst = 0 asynchronously mid-game at score 42 -> outputs zero immediately, without waiting for a clock edge; state = IDLE.

Source files
------------

// File: rtl/score_keeper_if.sv
// Control pulses into the score keeper and its registered game-status outputs.
// The master modport drives play controls; the slave modport is the score keeper itself.
interface score_keeper_if;
  logic        enable;
  logic        start;
  logic        hit;
  logic        miss;
  logic [11:0] score_bcd;
  logic [2:0]  lives_left;
  logic [2:0]  level;
  logic [7:0]  streak;
  logic        playing;
  logic        game_over;

  modport master (
    output enable, start, hit, miss,
    input  score_bcd, lives_left, level, streak, playing, game_over
  );

  modport slave (
    input  enable, start, hit, miss,
    output score_bcd, lives_left, level, streak, playing, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// Game score keeper: IDLE/PLAY/OVER FSM with BCD score, lives, level and streak; outputs registered, one-edge latency.
// No backpressure: hit/miss pulses are consumed only in PLAY with enable high, otherwise dropped.
module score_keeper #(
  parameter int LIVES          = 3,
  parameter int HITS_PER_LEVEL = 8,
  parameter int MAX_LEVEL      = 7
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave sk
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);
  localparam logic [8:0] HIT_WRAP   = 9'(HITS_PER_LEVEL);

  state_e     state_q, state_d;
  logic [3:0] hun_q, hun_d;
  logic [3:0] ten_q, ten_d;
  logic [3:0] one_q, one_d;
  logic [2:0] lives_q, lives_d;
  logic [2:0] level_q, level_d;
  logic [7:0] streak_q, streak_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;

  logic       accept_hit;
  logic       accept_miss;
  logic       score_max;
  logic [3:0] hun_inc, ten_inc, one_inc;
  logic [8:0] hit_cnt_inc;

  always_comb begin
    accept_hit  = (state_q == S_PLAY) && sk.enable && sk.hit;
    // A simultaneous hit wins; the miss is discarded.
    accept_miss = (state_q == S_PLAY) && sk.enable && sk.miss && !sk.hit;
    score_max   = (hun_q == 4'd9) && (ten_q == 4'd9) && (one_q == 4'd9);
    hit_cnt_inc = {1'b0, hit_cnt_q} + 9'd1;
  end

  // Decimal increment with ripple carry; saturates at 999.
  always_comb begin
    hun_inc = hun_q;
    ten_inc = ten_q;
    one_inc = one_q;
    if (!score_max) begin
      if (one_q == 4'd9) begin
        one_inc = 4'd0;
        if (ten_q == 4'd9) begin
          ten_inc = 4'd0;
          hun_inc = hun_q + 4'd1;
        end else begin
          ten_inc = ten_q + 4'd1;
        end
      end else begin
        one_inc = one_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hun_d     = hun_q;
    ten_d     = ten_q;
    one_d     = one_q;
    lives_d   = lives_q;
    level_d   = level_q;
    streak_d  = streak_q;
    hit_cnt_d = hit_cnt_q;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (sk.start) begin
          state_d   = S_PLAY;
          hun_d     = 4'd0;
          ten_d     = 4'd0;
          one_d     = 4'd0;
          lives_d   = LIVES_INIT;
          level_d   = 3'd0;
          streak_d  = 8'd0;
          hit_cnt_d = 8'd0;
        end
      end
      S_PLAY: begin
        if (accept_hit) begin
          hun_d = hun_inc;
          ten_d = ten_inc;
          one_d = one_inc;
          if (streak_q != 8'hFF) begin
            streak_d = streak_q + 8'd1;
          end
          // The hit counter keeps wrapping even once the level has saturated.
          if (hit_cnt_inc == HIT_WRAP) begin
            hit_cnt_d = 8'd0;
            if (level_q < LEVEL_MAX) begin
              level_d = level_q + 3'd1;
            end
          end else begin
            hit_cnt_d = hit_cnt_inc[7:0];
          end
        end else if (accept_miss) begin
          streak_d = 8'd0;
          if (lives_q != 3'd0) begin
            lives_d = lives_q - 3'd1;
          end
          if (lives_q <= 3'd1) begin
            state_d = S_OVER;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hun_q     <= 4'd0;
      ten_q     <= 4'd0;
      one_q     <= 4'd0;
      lives_q   <= 3'd0;
      level_q   <= 3'd0;
      streak_q  <= 8'd0;
      hit_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      hun_q     <= hun_d;
      ten_q     <= ten_d;
      one_q     <= one_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      streak_q  <= streak_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign sk.score_bcd  = {hun_q, ten_q, one_q};
  assign sk.lives_left = lives_q;
  assign sk.level      = level_q;
  assign sk.streak     = streak_q;
  assign sk.playing    = (state_q == S_PLAY);
  assign sk.game_over  = (state_q == S_OVER);

  a_status_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(sk.playing && sk.game_over));
  a_bcd_digits: assert property (@(posedge clk) disable iff (!rst)
    (hun_q <= 4'd9) && (ten_q <= 4'd9) && (one_q <= 4'd9));
  a_over_no_lives: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_OVER) |-> (lives_q == 3'd0));

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios with literal expectations plus randomized play,
// all outputs compared every cycle against an integer-arithmetic game model.
module tb_score_keeper;
  localparam int LIVES = 3;
  localparam int HPL   = 8;
  localparam int MAXL  = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  score_keeper_if sk();

  score_keeper #(
    .LIVES(LIVES),
    .HITS_PER_LEVEL(HPL),
    .MAX_LEVEL(MAXL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sk(sk)
  );

  always #5 clk = ~clk;

  // Game model: 0 idle, 1 play, 2 over; score held as a plain decimal integer.
  int m_state  = 0;
  int m_score  = 0;
  int m_lives  = 0;
  int m_level  = 0;
  int m_streak = 0;
  int m_hits   = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst) begin
    m_state = 0; m_score = 0; m_lives = 0; m_level = 0; m_streak = 0; m_hits = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (m_state != 1) begin
        if (sk.start) begin
          m_state = 1; m_score = 0; m_lives = LIVES; m_level = 0; m_streak = 0; m_hits = 0;
        end
      end else if (sk.enable && sk.hit) begin
        m_score  = (m_score < 999) ? m_score + 1 : 999;
        m_streak = (m_streak < 255) ? m_streak + 1 : 255;
        m_hits   = m_hits + 1;
        if (m_hits == HPL) begin
          m_hits  = 0;
          m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
        end
      end else if (sk.enable && sk.miss) begin
        m_streak = 0;
        m_lives  = m_lives - 1;
        if (m_lives == 0) m_state = 2;
      end
    end
  end

  always @(negedge clk) begin
    chk("score", int'(sk.score_bcd), int'(to_bcd(m_score)));
    chk("lives", int'(sk.lives_left), m_lives);
    chk("level", int'(sk.level), m_level);
    chk("streak", int'(sk.streak), m_streak);
    chk("playing", int'(sk.playing), int'(m_state == 1));
    chk("game_over", int'(sk.game_over), int'(m_state == 2));
  end

  task automatic cyc(input logic e, input logic s, input logic h, input logic m);
    sk.enable = e; sk.start = s; sk.hit = h; sk.miss = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sk.enable = 1'b0; sk.start = 1'b0; sk.hit = 1'b0; sk.miss = 1'b0;
    repeat (3) cyc(1, 1, 1, 0);
    chk("rst_score", int'(sk.score_bcd), 0);
    chk("rst_playing", int'(sk.playing), 0);
    chk("rst_over", int'(sk.game_over), 0);
    rst = 1'b1;

    // Idle ignores hits and stays idle without start.
    repeat (3) cyc(1, 0, 1, 1);
    chk("idle_hold", int'(sk.playing), 0);
    cyc(1, 1, 0, 0);
    chk("start_play", int'(sk.playing), 1);
    chk("start_lives", int'(sk.lives_left), 3);
    chk("start_score", int'(sk.score_bcd), 12'h000);
    chk("start_level", int'(sk.level), 0);

    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0);
    chk("ten_score", int'(sk.score_bcd), 12'h010);
    chk("ten_streak", int'(sk.streak), 10);
    chk("ten_level", int'(sk.level), 1);

    cyc(1, 0, 1, 1);
    chk("both_score", int'(sk.score_bcd), 12'h011);
    chk("both_lives", int'(sk.lives_left), 3);
    chk("both_streak", int'(sk.streak), 11);

    cyc(1, 1, 0, 0);
    chk("start_in_play", int'(sk.score_bcd), 12'h011);
    cyc(0, 0, 0, 1);
    chk("paused_miss", int'(sk.lives_left), 3);

    cyc(1, 0, 0, 1);
    chk("miss1", int'(sk.lives_left), 2);
    chk("miss1_streak", int'(sk.streak), 0);
    cyc(1, 0, 0, 1);
    chk("miss2", int'(sk.lives_left), 1);
    cyc(1, 0, 0, 1);
    chk("miss3", int'(sk.lives_left), 0);
    chk("over", int'(sk.game_over), 1);
    cyc(1, 0, 1, 0);
    chk("over_hit", int'(sk.score_bcd), 12'h011);
    cyc(1, 1, 0, 0);
    chk("restart_play", int'(sk.playing), 1);
    chk("restart_score", int'(sk.score_bcd), 12'h000);

    for (int i = 0; i < 1000; i++) cyc(1, 0, 1, 0);
    chk("sat_score", int'(sk.score_bcd), 12'h999);
    chk("sat_streak", int'(sk.streak), 255);
    chk("sat_level", int'(sk.level), 7);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    chk("pause_score", int'(sk.score_bcd), 12'h999);

    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) != 0, ($urandom % 40) == 0,
          ($urandom % 3) == 0, ($urandom % 10) == 0);
    end

    // Asynchronous reset mid-game at score 42, away from any clock edge.
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 42; i++) cyc(1, 0, 1, 0);
    chk("pre_rst_score", int'(sk.score_bcd), 12'h042);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_score", int'(sk.score_bcd), 0);
    chk("arst_lives", int'(sk.lives_left), 0);
    chk("arst_level", int'(sk.level), 0);
    chk("arst_streak", int'(sk.streak), 0);
    chk("arst_playing", int'(sk.playing), 0);
    chk("arst_over", int'(sk.game_over), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) cyc(1, 0, 1, 0);
    chk("post_rst_idle", int'(sk.playing), 0);
    chk("post_rst_score", int'(sk.score_bcd), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
